// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and width helpers shared by the PLL
// bring-up sequencer and its lock-window checker.
package pll_seq_pkg;

  // Sequencer states; the encoding is exported on state_o.
  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4,
    ST_BRAKE  = 3'd5
  } pll_state_e;

  // Width of the fb_tick window count, which saturates at 2*WIN.
  function automatic int win_cnt_w(input int win);
    return $clog2(2 * win + 1);
  endfunction

  // Bits needed to hold the value maxval (at least one bit).
  function automatic int cnt_w(input int maxval);
    if (maxval <= 1) return 1;
    return $clog2(maxval + 1);
  endfunction

  // Ceiling of the saturating relock debug counter.
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

endpackage

// File: rtl/pll_seq_win.sv
// pll_seq_win: back-to-back WIN-cycle windows counting fb_tick pulses.
// At the end of each window win_done pulses for one cycle together with
// win_pass, which is high when the count lies within WIN +/- TOL.
module pll_seq_win
  import pll_seq_pkg::*;
#(
  parameter int WIN = 64,
  parameter int TOL = 1
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  input  logic fb_tick,
  output logic win_done,
  output logic win_pass
);

  localparam int CW = win_cnt_w(WIN);
  localparam int PW = cnt_w(WIN - 1);
  localparam logic [CW-1:0] SAT = CW'(2 * WIN);
  localparam logic [CW-1:0] LO  = (WIN > TOL) ? CW'(WIN - TOL) : '0;
  localparam logic [CW-1:0] HI  = (TOL >= WIN) ? SAT : CW'(WIN + TOL);

  logic [PW-1:0] r_pos;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_pass;
  logic [CW-1:0] w_cnt_inc;
  logic          w_last;

  // The final cycle's tick is folded in so no pulse is lost at window end.
  assign w_cnt_inc = (fb_tick && (r_cnt != SAT)) ? r_cnt + CW'(1) : r_cnt;
  assign w_last    = (r_pos == PW'(WIN - 1));

  // Window position and tick count; the next window starts with no gap.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      r_pos  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (enable) begin
      r_done <= w_last;
      r_pass <= w_last && (w_cnt_inc >= LO) && (w_cnt_inc <= HI);
      if (w_last) begin
        r_pos <= '0;
        r_cnt <= '0;
      end else begin
        r_pos <= r_pos + PW'(1);
        r_cnt <= w_cnt_inc;
      end
    end else begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end
  end

  assign win_done = r_done;
  assign win_pass = r_pass;

endmodule

// File: rtl/pll_seq.sv
// pll_seq: PLL bring-up sequencer (reset hold, settle, lock qualification,
// run, brake) with run-time divider re-programming over valid/ready.
// Optional build macro PLL_SEQ_RELOCK_EN: lock loss retries through SETTLE
// and a saturating relock debug counter is kept; otherwise lock loss faults.
module pll_seq
  import pll_seq_pkg::*;
#(
  parameter int NW            = 8,
  parameter int N_DEFAULT     = 32,
  parameter int RESET_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 256,
  parameter int WIN           = 64,
  parameter int TOL           = 1,
  parameter int MAX_TRIES     = 8,
  parameter int RUN_CYCLES    = 0
) (
  input  logic          refclk,
  input  logic          reset,
  input  logic          fb_tick,
  input  logic          brake_req,
  input  logic          n_valid,
  input  logic [NW-1:0] n_data,
  output logic          n_ready,
  output logic          pll_resetn,
  output logic          pll_brake,
  output logic [NW-1:0] pll_n,
  output logic          locked,
  output logic          fault,
  output logic [2:0]    state_o
);

  localparam int HW = cnt_w(RESET_CYCLES - 1);
  localparam int SW = cnt_w(SETTLE_CYCLES - 1);
  localparam int TW = cnt_w(MAX_TRIES);
  localparam int RW = cnt_w(RUN_CYCLES);

  pll_state_e    r_state;
  logic [HW-1:0] r_hold;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_tries;
  logic [RW-1:0] r_run;
  logic          r_pll_resetn;
  logic          r_pll_brake;
  logic [NW-1:0] r_pll_n;
  logic          r_locked;
  logic          r_fault;

  logic w_win_done;
  logic w_win_pass;
  logic w_win_en;
  logic w_xfer_new;
  logic w_lock_loss;
  logic w_run_done;

  // Windows run only while qualifying or holding lock; elsewhere they are held clear.
  assign w_win_en = (r_state == ST_CHECK) || (r_state == ST_LOCKED);

  pll_seq_win #(
    .WIN (WIN),
    .TOL (TOL)
  ) u_win (
    .clk      (refclk),
    .srst     (reset),
    .clear    (!w_win_en),
    .enable   (w_win_en),
    .fb_tick  (fb_tick),
    .win_done (w_win_done),
    .win_pass (w_win_pass)
  );

  assign n_ready = ((r_state == ST_LOCKED) || (r_state == ST_FAULT)) && !brake_req;

  // A zero ratio is consumed by the handshake but otherwise has no effect.
  assign w_xfer_new = n_valid && n_ready && (n_data != '0);

  assign w_lock_loss = (r_state == ST_LOCKED) && !brake_req && !w_xfer_new &&
                       w_win_done && !w_win_pass;

  assign w_run_done = (RUN_CYCLES != 0) && (r_run == RW'(RUN_CYCLES - 1));

  // Sequencer FSM; brake_req outranks handshakes and window results.
  always_ff @(posedge refclk) begin
    if (reset) begin
      r_state      <= ST_HOLD;
      r_hold       <= '0;
      r_settle     <= '0;
      r_tries      <= '0;
      r_run        <= '0;
      r_pll_resetn <= 1'b0;
      r_pll_brake  <= 1'b0;
      r_pll_n      <= NW'(N_DEFAULT);
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold == HW'(RESET_CYCLES - 1)) begin
            r_state      <= ST_SETTLE;
            r_pll_resetn <= 1'b1;
            r_hold       <= '0;
            r_settle     <= '0;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end

        ST_SETTLE: begin
          if (brake_req) begin
            r_state     <= ST_BRAKE;
            r_pll_brake <= 1'b1;
            r_locked    <= 1'b0;
          end else if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
            r_state  <= ST_CHECK;
            r_settle <= '0;
            r_tries  <= '0;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end

        ST_CHECK: begin
          if (brake_req) begin
            r_state     <= ST_BRAKE;
            r_pll_brake <= 1'b1;
            r_locked    <= 1'b0;
          end else if (w_win_done) begin
            if (w_win_pass) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_run    <= '0;
            end else begin
              r_tries <= r_tries + TW'(1);
              if (r_tries == TW'(MAX_TRIES - 1)) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end
            end
          end
        end

        ST_LOCKED: begin
          if (brake_req) begin
            r_state     <= ST_BRAKE;
            r_pll_brake <= 1'b1;
            r_locked    <= 1'b0;
          end else if (w_xfer_new) begin
            r_state      <= ST_HOLD;
            r_pll_n      <= n_data;
            r_pll_resetn <= 1'b0;
            r_hold       <= '0;
            r_tries      <= '0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
          end else if (w_lock_loss) begin
            r_locked <= 1'b0;
`ifdef PLL_SEQ_RELOCK_EN
            r_state  <= ST_SETTLE;
            r_settle <= '0;
            r_tries  <= '0;
`else
            r_state  <= ST_FAULT;
            r_fault  <= 1'b1;
`endif
          end else if (w_run_done) begin
            r_state     <= ST_BRAKE;
            r_pll_brake <= 1'b1;
            r_locked    <= 1'b0;
          end else if (RUN_CYCLES != 0) begin
            r_run <= r_run + RW'(1);
          end
        end

        ST_FAULT: begin
          if (brake_req) begin
            r_state     <= ST_BRAKE;
            r_pll_brake <= 1'b1;
            r_locked    <= 1'b0;
          end else if (w_xfer_new) begin
            r_state      <= ST_HOLD;
            r_pll_n      <= n_data;
            r_pll_resetn <= 1'b0;
            r_hold       <= '0;
            r_tries      <= '0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
          end
        end

        ST_BRAKE: begin
          // Terminal: PLL stays braked with resetn and N frozen until reset.
          r_pll_brake <= 1'b1;
          r_locked    <= 1'b0;
        end

        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_RELOCK_EN
  logic [7:0] r_relock_cnt;

  // Debug tally of lock losses that triggered a relock attempt.
  always_ff @(posedge refclk) begin
    if (reset) begin
      r_relock_cnt <= '0;
    end else if (w_lock_loss && (r_relock_cnt != RELOCK_MAX)) begin
      r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end
`endif

  assign pll_resetn = r_pll_resetn;
  assign pll_brake  = r_pll_brake;
  assign pll_n      = r_pll_n;
  assign locked     = r_locked;
  assign fault      = r_fault;
  assign state_o    = r_state;

endmodule

// File: tb/tb_pll_seq.sv
// tb_pll_seq: scoreboard bench for pll_seq. Expectations are queued as
// stimulus is applied and popped against DUT outputs sampled on negedge.
// A second instance with RUN_CYCLES=1000 covers the timed brake.
`timescale 1ns/1ps
module tb_pll_seq;
  import pll_seq_pkg::*;

  localparam int WIN_L = 64;
  localparam int TRIES_L = 8;

  logic       refclk = 1'b0;
  logic       reset, fb_tick, brake_req, n_valid;
  logic [7:0] n_data;
  logic       n_ready, pll_resetn, pll_brake, locked, fault;
  logic [7:0] pll_n;
  logic [2:0] state_o;

  logic       reset2, fb2, brake2, nvalid2;
  logic [7:0] ndata2;
  logic       nready2, resetn2, pbrake2, locked2, fault2;
  logic [7:0] pll_n2;
  logic [2:0] state2;

  always #5 refclk = ~refclk;

  pll_seq dut (
    .refclk(refclk), .reset(reset), .fb_tick(fb_tick), .brake_req(brake_req),
    .n_valid(n_valid), .n_data(n_data), .n_ready(n_ready),
    .pll_resetn(pll_resetn), .pll_brake(pll_brake), .pll_n(pll_n),
    .locked(locked), .fault(fault), .state_o(state_o)
  );

  pll_seq #(.RUN_CYCLES(1000)) dut_run (
    .refclk(refclk), .reset(reset2), .fb_tick(fb2), .brake_req(brake2),
    .n_valid(nvalid2), .n_data(ndata2), .n_ready(nready2),
    .pll_resetn(resetn2), .pll_brake(pbrake2), .pll_n(pll_n2),
    .locked(locked2), .fault(fault2), .state_o(state2)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int unsigned exp;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int unsigned obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      $display("FAIL sb_underflow: got 0 entries, want 1");
      $fatal(1, "scoreboard underflow");
    end
    e = sb_q.pop_front();
    check_val(e.tag, obs, e.exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return locked == 1'b1;
      1: return locked == 1'b0;
      2: return state_o == ST_CHECK;
      3: return fault == 1'b1;
      4: return locked2 == 1'b1;
      default: return pbrake2 == 1'b1;
    endcase
  endfunction

  // Counts cycles until the selected condition holds, bounded by limit.
  task automatic wait_for(input int which, input int limit, output int c);
    c = 0;
    while (!cond(which) && c < limit) begin
      tick(1);
      c++;
    end
  endtask

  task automatic handshake(input logic [7:0] val);
    n_valid = 1'b1;
    n_data  = val;
    tick(1);
    n_valid = 1'b0;
  endtask

  // Feedback pattern: 0 = every cycle, 1 = every other, 2 = 60 of 64, else none.
  int fb_mode = 0;
  int fb_phase = 0;
  initial begin
    fb_tick = 1'b0;
    forever begin
      @(negedge refclk);
      fb_phase = (fb_phase + 1) % 64;
      case (fb_mode)
        0:       fb_tick = 1'b1;
        1:       fb_tick = fb_phase[0];
        2:       fb_tick = (fb_phase < 60);
        default: fb_tick = 1'b0;
      endcase
    end
  end

  initial begin
    int c;
    reset = 1'b1; brake_req = 1'b0; n_valid = 1'b0; n_data = '0;
    reset2 = 1'b1; fb2 = 1'b1; brake2 = 1'b0; nvalid2 = 1'b0; ndata2 = '0;
    tick(3);

    sb_push("rst_resetn", 0); sb_push("rst_brake", 0); sb_push("rst_pll_n", 32);
    sb_push("rst_locked", 0); sb_push("rst_fault", 0); sb_push("rst_state", ST_HOLD);
    sb_push("rst_ready", 0);
    sb_pop(pll_resetn); sb_pop(pll_brake); sb_pop(pll_n);
    sb_pop(locked); sb_pop(fault); sb_pop(state_o); sb_pop(n_ready);

    // Reset release: resetn rises after two HOLD cycles, CHECK 256 later.
    sb_push("hold_c1_resetn", 0);
    reset = 1'b0;
    tick(1); sb_pop(pll_resetn);
    sb_push("hold_c2_resetn", 1); sb_push("settle_state", ST_SETTLE);
    tick(1); sb_pop(pll_resetn); sb_pop(state_o);
    sb_push("settle_len", ST_SETTLE);
    tick(255); sb_pop(state_o);
    sb_push("check_state", ST_CHECK);
    tick(1); sb_pop(state_o);

    sb_push("lock_latency", WIN_L + 1); sb_push("locked_pll_n", 32); sb_push("locked_ready", 1);
    wait_for(0, 200, c);
    sb_pop(c); sb_pop(pll_n); sb_pop(n_ready);

    // Zero ratio is consumed and ignored.
    sb_push("zero_state", ST_LOCKED); sb_push("zero_pll_n", 32); sb_push("zero_locked", 1);
    handshake(8'd0);
    sb_pop(state_o); sb_pop(pll_n); sb_pop(locked);

    // New ratio 40 re-resets the PLL and relocks.
    sb_push("hs_pll_n", 40); sb_push("hs_locked", 0); sb_push("hs_state", ST_HOLD);
    sb_push("hs_resetn", 0);
    handshake(8'd40);
    sb_pop(pll_n); sb_pop(locked); sb_pop(state_o); sb_pop(pll_resetn);
    sb_push("rehold_resetn", 0);
    tick(1); sb_pop(pll_resetn);
    sb_push("rehold_release", 1);
    tick(1); sb_pop(pll_resetn);
    sb_push("relock", 1);
    wait_for(0, 500, c); sb_pop(locked);

    // 60 ticks per window falls outside 64 +/- 1.
    sb_push("loss_locked", 0);
`ifdef PLL_SEQ_RELOCK_EN
    sb_push("loss_state", ST_SETTLE); sb_push("loss_fault", 0);
`else
    sb_push("loss_state", ST_FAULT); sb_push("loss_fault", 1);
`endif
    fb_mode = 2;
    wait_for(1, 300, c);
    sb_pop(locked); sb_pop(state_o); sb_pop(fault);
`ifdef PLL_SEQ_RELOCK_EN
    sb_push("relock_after_loss", 1);
    fb_mode = 0;
    wait_for(0, 500, c); sb_pop(locked);
`endif

    // Half-rate feedback: eight failing windows then FAULT.
    sb_push("pre_fault_ready", 1);
    sb_pop(n_ready);
    fb_mode = 1;
    handshake(8'd32);
    wait_for(2, 400, c);
    sb_push("fault_latency", TRIES_L * WIN_L + 1); sb_push("fault_flag", 1);
    sb_push("fault_ready", 1); sb_push("fault_state", ST_FAULT); sb_push("fault_locked", 0);
    wait_for(3, 800, c);
    sb_pop(c); sb_pop(fault); sb_pop(n_ready); sb_pop(state_o); sb_pop(locked);

    // Leave FAULT with a new ratio and relock.
    sb_push("fault_exit", 0); sb_push("fault_exit_state", ST_HOLD);
    fb_mode = 0;
    handshake(8'd40);
    sb_pop(fault); sb_pop(state_o);
    sb_push("relock2", 1);
    wait_for(0, 500, c); sb_pop(locked);

    // brake_req together with n_valid: brake wins, N unchanged.
    sb_push("brk_ready", 0);
    brake_req = 1'b1; n_valid = 1'b1; n_data = 8'd50;
    #1 sb_pop(n_ready);
    sb_push("brk_brake", 1); sb_push("brk_pll_n", 40); sb_push("brk_state", ST_BRAKE);
    sb_push("brk_locked", 0); sb_push("brk_resetn", 1);
    tick(1);
    brake_req = 1'b0; n_valid = 1'b0;
    sb_pop(pll_brake); sb_pop(pll_n); sb_pop(state_o); sb_pop(locked); sb_pop(pll_resetn);
    sb_push("brk_terminal", ST_BRAKE);
    tick(5); sb_pop(state_o);

    // Reset out of BRAKE.
    sb_push("rst2_brake", 0); sb_push("rst2_resetn", 0); sb_push("rst2_pll_n", 32);
    sb_push("rst2_state", ST_HOLD);
    reset = 1'b1;
    tick(1);
    sb_pop(pll_brake); sb_pop(pll_resetn); sb_pop(pll_n); sb_pop(state_o);
    reset = 1'b0;

    // Timed brake exactly RUN_CYCLES after lock.
    sb_push("run_locked", 1);
    reset2 = 1'b0;
    wait_for(4, 600, c); sb_pop(locked2);
    sb_push("run_len", 1000); sb_push("run_state", ST_BRAKE); sb_push("run_locked_off", 0);
    wait_for(5, 1100, c);
    sb_pop(c); sb_pop(state2); sb_pop(locked2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
